register_right_driver: RTL and testbench

Synchronous initiator for the edge-triggered saveReq/saveFin and rightReq/rightFin handshake of the asynchronous right-shift register. On a start command it loads a word into the register and then issues a programmed number of single-bit right shifts, each completed on the register's Fin response. It sits between clocked control logic and the self-timed register, synchronising the Fin returns and holding the load data stable for the whole operation.

---
 rtl/register_right_driver.sv | 200 ++++++++++++++++++++
 tb/tb_register_right_driver.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_right_driver.sv
// register_right_driver
//   Clocked initiator for the self-timed right-shift register. A start command
//   loads a word (saveReq/saveFin handshake) and then issues a programmed number
//   of single-bit right shifts (rightReq/rightFin handshake). Fin returns are
//   asynchronous and pass through 2-flop synchronisers before use.
//
//   Optional feature: define REGISTER_RIGHT_DRIVER_TIMEOUT_EN to build a per-
//   handshake watchdog that sets the sticky err flag and aborts the operation.
//   Without it the block waits indefinitely and err is tied low.
//
// Ports
//   clk, rstn              clock (rising edge), synchronous active-low reset
//   start                  command strobe, accepted only when idle
//   dataIn, shiftCount     load word and shift count, sampled on acceptance
//   busy, done, err        status: in operation, completion pulse, timeout flag
//   shiftsDone             shifts completed in the current or last operation
//   saveData, saveReq      load word and load request to the register
//   saveFin                load completion from the register (asynchronous)
//   rightReq               shift request to the register
//   rightFin               shift completion from the register (asynchronous)
module register_right_driver #(
    parameter int unsigned Width         = 32,
    parameter int unsigned CountWidth    = 6,
    parameter int unsigned ReqCycles     = 2,
    parameter int unsigned Settle        = 3,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [Width-1:0]      dataIn,
    input  logic [CountWidth-1:0] shiftCount,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CountWidth-1:0] shiftsDone,
    output logic [Width-1:0]      saveData,
    output logic                  saveReq,
    input  logic                  saveFin,
    output logic                  rightReq,
    input  logic                  rightFin
);

    typedef enum logic [2:0] {
        StIdle,
        StSaveReq,
        StSaveWait,
        StShiftReq,
        StShiftWait,
        StDone
    } state_e;

    // One phase counter serves both the Req hold time and the settle window.
    localparam int unsigned CycMax = (ReqCycles > Settle) ? ReqCycles : Settle;
    localparam int unsigned CycW   = $clog2(CycMax + 1);

    state_e                state_q, state_d;
    logic [CycW-1:0]       cyc_q, cyc_d;
    logic [Width-1:0]      data_q, data_d;
    logic [CountWidth-1:0] rem_q, rem_d;
    logic [CountWidth-1:0] shifts_q, shifts_d;
    logic                  save_req_q, save_req_d;
    logic                  right_req_q, right_req_d;
    logic [1:0]            save_sync_q, right_sync_q;
    logic                  save_fin_s, right_fin_s;
    logic                  settled;

`ifdef REGISTER_RIGHT_DRIVER_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TimeoutCycles + 1);
    logic [WdW-1:0] wdog_q, wdog_d;
    logic           err_q, err_d;
`endif

    assign save_fin_s  = save_sync_q[1];
    assign right_fin_s = right_sync_q[1];
    assign settled     = (cyc_q >= CycW'(Settle - 1));

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        rem_d       = rem_q;
        shifts_d    = shifts_q;
        // Saturate so a long wait for Fin cannot wrap the settle window.
        cyc_d       = (cyc_q == CycW'(CycMax)) ? cyc_q : cyc_q + 1'b1;
`ifdef REGISTER_RIGHT_DRIVER_TIMEOUT_EN
        err_d       = err_q;
        wdog_d      = '0;
`endif
        unique case (state_q)
            StIdle: begin
                cyc_d = '0;
                if (start) begin
                    data_d   = dataIn;
                    rem_d    = shiftCount;
                    shifts_d = '0;
`ifdef REGISTER_RIGHT_DRIVER_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = StSaveReq;
                end
            end
            StSaveReq: begin
                if (cyc_q == CycW'(ReqCycles - 1)) begin
                    cyc_d   = '0;
                    state_d = StSaveWait;
                end
            end
            StSaveWait: begin
                if (settled && save_fin_s) begin
                    cyc_d   = '0;
                    state_d = (rem_q == '0) ? StDone : StShiftReq;
                end
            end
            StShiftReq: begin
                if (cyc_q == CycW'(ReqCycles - 1)) begin
                    cyc_d   = '0;
                    state_d = StShiftWait;
                end
            end
            StShiftWait: begin
                if (settled && right_fin_s) begin
                    cyc_d    = '0;
                    shifts_d = shifts_q + 1'b1;
                    rem_d    = rem_q - 1'b1;
                    state_d  = (rem_q == CountWidth'(1)) ? StDone : StShiftReq;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
`ifdef REGISTER_RIGHT_DRIVER_TIMEOUT_EN
        // Watchdog runs only while a wait state is still waiting for its Fin.
        if ((state_q == StSaveWait || state_q == StShiftWait) && (state_d == state_q)) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_q == WdW'(TimeoutCycles - 1)) begin
                err_d   = 1'b1;
                wdog_d  = '0;
                state_d = StDone;
            end
        end
`endif
        // Req lines are registered so the self-timed register sees clean edges.
        save_req_d  = (state_d == StSaveReq);
        right_req_d = (state_d == StShiftReq);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            cyc_q        <= '0;
            data_q       <= '0;
            rem_q        <= '0;
            shifts_q     <= '0;
            save_req_q   <= 1'b0;
            right_req_q  <= 1'b0;
            save_sync_q  <= '0;
            right_sync_q <= '0;
`ifdef REGISTER_RIGHT_DRIVER_TIMEOUT_EN
            wdog_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            data_q       <= data_d;
            rem_q        <= rem_d;
            shifts_q     <= shifts_d;
            save_req_q   <= save_req_d;
            right_req_q  <= right_req_d;
            save_sync_q  <= {save_sync_q[0], saveFin};
            right_sync_q <= {right_sync_q[0], rightFin};
`ifdef REGISTER_RIGHT_DRIVER_TIMEOUT_EN
            wdog_q       <= wdog_d;
            err_q        <= err_d;
`endif
        end
    end

`ifdef REGISTER_RIGHT_DRIVER_TIMEOUT_EN
    assign err = err_q;
`else
    // TimeoutCycles only matters when the watchdog is built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TimeoutCycles;
    assign err = 1'b0;
`endif

    // Gating with rstn drops both Req lines as soon as reset is asserted.
    assign saveReq    = save_req_q & rstn;
    assign rightReq   = right_req_q & rstn;
    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign done       = (state_q == StDone);
    assign shiftsDone = shifts_q;
    assign saveData   = data_q;

endmodule

// File: tb/tb_register_right_driver.sv
// Scoreboard bench for register_right_driver with a behavioural model of the
// self-timed right-shift register answering saveReq/rightReq.
module tb_register_right_driver;

    localparam int unsigned Width         = 32;
    localparam int unsigned CountWidth    = 6;
    localparam int unsigned ReqCycles     = 2;
    localparam int unsigned Settle        = 3;
    localparam int unsigned TimeoutCycles = 255;

    logic                  clk;
    logic                  rstn;
    logic                  start;
    logic [Width-1:0]      dataIn;
    logic [CountWidth-1:0] shiftCount;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [CountWidth-1:0] shiftsDone;
    logic [Width-1:0]      saveData;
    logic                  saveReq;
    logic                  saveFin;
    logic                  rightReq;
    logic                  rightFin;

    register_right_driver #(
        .Width        (Width),
        .CountWidth   (CountWidth),
        .ReqCycles    (ReqCycles),
        .Settle       (Settle),
        .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .dataIn    (dataIn),
        .shiftCount(shiftCount),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .shiftsDone(shiftsDone),
        .saveData  (saveData),
        .saveReq   (saveReq),
        .saveFin   (saveFin),
        .rightReq  (rightReq),
        .rightFin  (rightFin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- register model ----------------
    logic [Width-1:0] mreg = '0;
    int unsigned spulse = 0;
    int unsigned rpulse = 0;
    int unsigned save_dly = 1;
    int unsigned right_dly = 1;
    bit save_stuck = 1'b0;

    initial begin
        saveFin = 1'b0;
        forever begin
            @(posedge saveReq);
            #1;
            saveFin = 1'b0;
            mreg = saveData;
            spulse++;
            if (!save_stuck) begin
                repeat (save_dly) @(posedge clk);
                #1 saveFin = 1'b1;
            end
        end
    end

    initial begin
        rightFin = 1'b0;
        forever begin
            @(posedge rightReq);
            #1;
            rightFin = 1'b0;
            mreg = mreg >> 1;
            rpulse++;
            repeat (right_dly) @(posedge clk);
            #1 rightFin = 1'b1;
        end
    end

    // ---------------- Req protocol watcher ----------------
    int s_hi = 0, s_lo = 0, r_hi = 0, r_lo = 0;
    bit s_prev = 0, r_prev = 0, s_seen = 0, r_seen = 0;
    int viol_both = 0, viol_width = 0, viol_gap = 0;

    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            s_hi = 0; s_lo = 0; r_hi = 0; r_lo = 0;
            s_prev = 0; r_prev = 0; s_seen = 0; r_seen = 0;
        end else begin
            if (saveReq && rightReq) viol_both++;
            if (saveReq) begin
                if (!s_prev && s_seen && s_lo < Settle) viol_gap++;
                s_hi++;
                s_lo = 0;
            end else begin
                if (s_prev) begin
                    if (s_hi != ReqCycles) viol_width++;
                    s_seen = 1;
                    s_hi = 0;
                end
                s_lo++;
            end
            if (rightReq) begin
                if (!r_prev && r_seen && r_lo < Settle) viol_gap++;
                r_hi++;
                r_lo = 0;
            end else begin
                if (r_prev) begin
                    if (r_hi != ReqCycles) viol_width++;
                    r_seen = 1;
                    r_hi = 0;
                end
                r_lo++;
            end
            s_prev = saveReq;
            r_prev = rightReq;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int unsigned      shifts;
        bit               err;
        logic [Width-1:0] out;
        int unsigned      lat;
        bit               exact;
        int unsigned      start_cyc;
        int unsigned      sbase;
        int unsigned      rbase;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin : monitor
        exp_t        e;
        int unsigned lat;
        if (rstn === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                lat = cyc + 1 - e.start_cyc;
                check("done_shiftsDone", shiftsDone, e.shifts);
                check("done_err", err, e.err);
                check("done_busy_low", busy, 0);
                check("model_out", mreg, e.out);
                check("save_pulses", spulse - e.sbase, 1);
                check("right_pulses", rpulse - e.rbase, e.shifts);
                if (e.exact) check("latency", lat, e.lat);
                else         check("latency_min", lat >= e.lat, 1);
            end
        end
    end

    task automatic run_op(input logic [Width-1:0] d, input int unsigned n,
                          input int unsigned xs, input bit xe, input logic [Width-1:0] xo,
                          input int unsigned xl, input bit ex, input int unsigned budget);
        exp_t e;
        @(negedge clk);
        e.sbase = spulse;
        e.rbase = rpulse;
        start = 1'b1;
        dataIn = d;
        shiftCount = CountWidth'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        e.start_cyc = cyc;
        e.shifts = xs;
        e.err = xe;
        e.out = xo;
        e.lat = xl;
        e.exact = ex;
        sb.push_back(e);
        check("accept_busy", busy, 1);
        check("accept_err_clear", err, 0);
        check("accept_saveData", saveData, d);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL op_timeout: no done within %0d clocks, expected one", budget);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned base;
        rstn = 1'b0;
        start = 1'b1;
        dataIn = '1;
        shiftCount = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_done_err", {busy, done, err}, 0);
        check("rst_shiftsDone", shiftsDone, 0);
        check("rst_saveData", saveData, 0);
        check("rst_req", {saveReq, rightReq}, 0);
        check("rst_no_req_activity", spulse + rpulse, 0);
        @(negedge clk);
        start = 1'b0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // load only, load+shift, single shift, maximum count
        run_op(32'hA5A5A5A5, 0, 0, 0, 32'hA5A5A5A5, 6, 1, 50);
        run_op(32'h80000000, 4, 4, 0, 32'h08000000, 26, 1, 100);
        run_op(32'h00000003, 1, 1, 0, 32'h00000001, 11, 1, 50);
        run_op(32'hFFFFFFFF, 63, 63, 0, 32'h00000000, 321, 1, 500);

        // slow responder with an ignored start mid-operation
        right_dly = 20;
        fork
            run_op(32'h0000F0F0, 2, 2, 0, 32'h00003C3C, 16, 0, 200);
            begin
                repeat (30) @(negedge clk);
                check("busy_mid_op", busy, 1);
                start = 1'b1;
                dataIn = 32'hDEADBEEF;
                shiftCount = 7;
                @(negedge clk);
                start = 1'b0;
            end
        join
        right_dly = 1;
        check("saveData_held", saveData, 32'h0000F0F0);
        repeat (5) @(negedge clk);
        check("start_not_queued", {busy, done}, 0);

        // reset during the second SHIFT_REQ
        @(negedge clk);
        base = rpulse;
        start = 1'b1;
        dataIn = 32'h12345678;
        shiftCount = 5;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 100 && (rpulse - base) < 2; k++) @(negedge clk);
        check("reach_second_shift", rpulse - base, 2);
        check("shiftsDone_before_rst", shiftsDone, 1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("rst_req_drop_immediate", rightReq, 0);
        @(posedge clk);
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_req", {saveReq, rightReq}, 0);
        check("rst_mid_shiftsDone", shiftsDone, 0);
        check("rst_mid_done", done, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        run_op(32'h0000000F, 1, 1, 0, 32'h00000007, 11, 1, 50);

`ifdef REGISTER_RIGHT_DRIVER_TIMEOUT_EN
        save_stuck = 1'b1;
        run_op(32'h11112222, 3, 0, 1, 32'h11112222, 1 + ReqCycles + TimeoutCycles, 1, 400);
        save_stuck = 1'b0;
        check("timeout_err_sticky", err, 1);
        run_op(32'h0000000F, 1, 1, 0, 32'h00000007, 11, 1, 50);
`endif

        check("req_never_both_high", viol_both, 0);
        check("req_width", viol_width, 0);
        check("req_gap", viol_gap, 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
